// File: rtl/ltc2313_acq_ctrl.sv
// rtl/ltc2313_acq_ctrl.sv - LTC2313-14 conversion scheduler, result capture and sample delivery
// Optional ACQ_AVG_EN: each delivered sample is the truncated mean of 2^AVG_LOG2 captures.
module ltc2313_acq_ctrl #(
   parameter int DATA_WIDTH = 14,
   parameter int PERIOD     = 80,
   parameter int TIMEOUT    = 255
`ifdef ACQ_AVG_EN
   ,
   parameter int AVG_LOG2   = 2
`endif
) (
   input  logic                  i_clk,
   input  logic                  i_fRST,
   input  logic                  i_acq_en,
   input  logic                  i_single,
   input  logic                  i_clr_err,
   input  logic [2:0]            i_spi_state,
   input  logic [DATA_WIDTH-1:0] i_spi_miso_data,
   output logic                  o_spi_start,
   output logic [DATA_WIDTH-1:0] o_spi_mosi_data,
   output logic [DATA_WIDTH-1:0] o_data,
   output logic                  o_valid,
   input  logic                  i_ready,
   output logic                  o_busy,
   output logic                  o_overrun,
   output logic                  o_missed,
   output logic                  o_timeout,
   output logic [31:0]           o_sample_cnt
);

   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_START     = 3'd1;
   localparam logic [2:0] S_WAIT_BUSY = 3'd2;
   localparam logic [2:0] S_WAIT_DONE = 3'd3;
   localparam logic [2:0] S_CAPTURE   = 3'd4;

   localparam int          TW       = $clog2(TIMEOUT + 1);
   localparam logic [15:0] PER_LAST = 16'(PERIOD - 1);
   localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

   logic [2:0]            state;
   logic [15:0]           per_cnt;
   logic [TW-1:0]         to_cnt;
   logic                  tick;
   logic                  request;
   logic                  waiting;
   logic                  to_hit;
   logic                  capture;
   logic                  load;
   logic [DATA_WIDTH-1:0] load_data;

   assign tick            = i_acq_en && (per_cnt == PER_LAST);
   assign request         = tick || (i_single && !i_acq_en);
   assign waiting         = (state == S_WAIT_BUSY) || (state == S_WAIT_DONE);
   assign to_hit          = waiting && (to_cnt == TO_LAST);
   assign capture         = (state == S_CAPTURE);
   assign o_spi_start     = (state == S_START);
   assign o_busy          = (state != S_IDLE);
   assign o_spi_mosi_data = '0;

   always_ff @(posedge i_clk or negedge i_fRST) begin
      if (!i_fRST) begin
         per_cnt <= '0;
      end else if (!i_acq_en || tick) begin
         per_cnt <= '0;
      end else begin
         per_cnt <= per_cnt + 16'd1;
      end
   end

   // The timeout budget covers both wait states together, so to_cnt is only cleared in START.
   always_ff @(posedge i_clk or negedge i_fRST) begin
      if (!i_fRST) begin
         state  <= S_IDLE;
         to_cnt <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (request) state <= S_START;
            end
            S_START: begin
               state  <= S_WAIT_BUSY;
               to_cnt <= '0;
            end
            S_WAIT_BUSY: begin
               if (to_hit) begin
                  state <= S_IDLE;
               end else begin
                  to_cnt <= to_cnt + TW'(1);
                  if (i_spi_state != 3'd0) state <= S_WAIT_DONE;
               end
            end
            S_WAIT_DONE: begin
               if (to_hit) begin
                  state <= S_IDLE;
               end else begin
                  to_cnt <= to_cnt + TW'(1);
                  if (i_spi_state == 3'd0) state <= S_CAPTURE;
               end
            end
            S_CAPTURE: state <= S_IDLE;
            default:   state <= S_IDLE;
         endcase
      end
   end

`ifdef ACQ_AVG_EN
   localparam int AW = DATA_WIDTH + AVG_LOG2;

   logic [AW-1:0]       accum;
   logic [AW-1:0]       accum_next;
   logic [AVG_LOG2-1:0] grp_cnt;

   assign accum_next = accum + AW'(i_spi_miso_data);
   assign load       = capture && (grp_cnt == '1);
   assign load_data  = DATA_WIDTH'(accum_next >> AVG_LOG2);

   always_ff @(posedge i_clk or negedge i_fRST) begin
      if (!i_fRST) begin
         accum   <= '0;
         grp_cnt <= '0;
      end else if (to_hit) begin
         accum   <= '0;
         grp_cnt <= '0;
      end else if (capture) begin
         accum   <= load ? '0 : accum_next;
         grp_cnt <= grp_cnt + AVG_LOG2'(1);
      end
   end
`else
   assign load      = capture;
   assign load_data = i_spi_miso_data;
`endif

   always_ff @(posedge i_clk or negedge i_fRST) begin
      if (!i_fRST) begin
         o_data       <= '0;
         o_valid      <= 1'b0;
         o_sample_cnt <= '0;
      end else if (load) begin
         o_data       <= load_data;
         o_valid      <= 1'b1;
         o_sample_cnt <= o_sample_cnt + 32'd1;
      end else if (o_valid && i_ready) begin
         o_valid <= 1'b0;
      end
   end

   // Error flags: a new event in the same cycle as i_clr_err keeps the flag set.
   always_ff @(posedge i_clk or negedge i_fRST) begin
      if (!i_fRST) begin
         o_overrun <= 1'b0;
         o_missed  <= 1'b0;
         o_timeout <= 1'b0;
      end else begin
         if (load && o_valid && !i_ready) o_overrun <= 1'b1;
         else if (i_clr_err)              o_overrun <= 1'b0;
         if (request && (state != S_IDLE)) o_missed <= 1'b1;
         else if (i_clr_err)               o_missed <= 1'b0;
         if (to_hit)         o_timeout <= 1'b1;
         else if (i_clr_err) o_timeout <= 1'b0;
      end
   end

endmodule

// File: tb/tb_ltc2313_acq_ctrl.sv
// tb/tb_ltc2313_acq_ctrl.sv - self-checking bench for ltc2313_acq_ctrl (PERIOD 80 and PERIOD 16 instances)
// Define ACQ_AVG_EN to run the averaging scenario in place of the per-sample data scenarios.
module tb_ltc2313_acq_ctrl;

   localparam int DW   = 14;
   localparam int BUSY = 28;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   n_chk  = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   logic          a_acq_en = 0, a_single = 0, a_clr = 0, a_ready = 0, a_stuck = 0;
   logic [2:0]    a_spi_state;
   logic [DW-1:0] a_miso, a_mosi, a_data;
   logic [DW-1:0] a_word = '0;
   logic          a_start, a_valid, a_busy, a_ovr, a_miss, a_to;
   logic [31:0]   a_cnt;
   int            a_left;

   logic          b_acq_en = 0, b_single = 0, b_clr = 0, b_ready = 0;
   logic [2:0]    b_spi_state;
   logic [DW-1:0] b_miso, b_mosi, b_data;
   logic          b_start, b_valid, b_busy, b_ovr, b_miss, b_to;
   logic [31:0]   b_cnt;
   int            b_left;

   ltc2313_acq_ctrl #(.DATA_WIDTH(DW), .PERIOD(80), .TIMEOUT(255)) dut (
      .i_clk(clk), .i_fRST(rst_n), .i_acq_en(a_acq_en), .i_single(a_single), .i_clr_err(a_clr),
      .i_spi_state(a_spi_state), .i_spi_miso_data(a_miso), .o_spi_start(a_start),
      .o_spi_mosi_data(a_mosi), .o_data(a_data), .o_valid(a_valid), .i_ready(a_ready),
      .o_busy(a_busy), .o_overrun(a_ovr), .o_missed(a_miss), .o_timeout(a_to), .o_sample_cnt(a_cnt)
   );

   ltc2313_acq_ctrl #(.DATA_WIDTH(DW), .PERIOD(16), .TIMEOUT(255)) dut16 (
      .i_clk(clk), .i_fRST(rst_n), .i_acq_en(b_acq_en), .i_single(b_single), .i_clr_err(b_clr),
      .i_spi_state(b_spi_state), .i_spi_miso_data(b_miso), .o_spi_start(b_start),
      .o_spi_mosi_data(b_mosi), .o_data(b_data), .o_valid(b_valid), .i_ready(b_ready),
      .o_busy(b_busy), .o_overrun(b_ovr), .o_missed(b_miss), .o_timeout(b_to), .o_sample_cnt(b_cnt)
   );

   // Model SPI masters: busy for BUSY cycles after a start, optionally stuck in state 2.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_spi_state <= 3'd0; a_left <= 0; a_miso <= '0;
      end else if (a_start) begin
         a_spi_state <= 3'd1; a_left <= BUSY - 1; a_miso <= a_word;
      end else if (a_spi_state != 3'd0) begin
         if (a_stuck)          a_spi_state <= 3'd2;
         else if (a_left == 0) a_spi_state <= 3'd0;
         else begin            a_spi_state <= 3'd2; a_left <= a_left - 1; end
      end
   end

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         b_spi_state <= 3'd0; b_left <= 0; b_miso <= '0;
      end else if (b_start) begin
         b_spi_state <= 3'd1; b_left <= BUSY - 1; b_miso <= 14'h0123;
      end else if (b_spi_state != 3'd0) begin
         if (b_left == 0) b_spi_state <= 3'd0;
         else begin       b_spi_state <= 3'd2; b_left <= b_left - 1; end
      end
   end

   task automatic do_reset();
      @(negedge clk);
      rst_n = 0;
      a_acq_en = 0; a_single = 0; a_clr = 0; a_ready = 0; a_stuck = 0; a_word = '0;
      b_acq_en = 0; b_single = 0; b_clr = 0; b_ready = 0;
      repeat (3) @(negedge clk);
      rst_n = 1;
   endtask

   task automatic test_reset();
      do_reset();
      n_chk++;
      if ({a_start, a_valid, a_busy, a_ovr, a_miss, a_to} !== 6'b0)
         begin n_fail++; $display("FAIL reset_flags: got %b expected 000000", {a_start, a_valid, a_busy, a_ovr, a_miss, a_to}); end
      n_chk++;
      if (a_data !== '0 || a_mosi !== '0 || a_cnt !== 32'd0)
         begin n_fail++; $display("FAIL reset_data: got data %0h mosi %0h cnt %0d expected 0", a_data, a_mosi, a_cnt); end
      n_chk++;
      if ({b_start, b_valid, b_busy, b_ovr, b_miss, b_to} !== 6'b0 || b_cnt !== 32'd0)
         begin n_fail++; $display("FAIL reset_dut16: got flags %b cnt %0d expected 0", {b_start, b_valid, b_busy, b_ovr, b_miss, b_to}, b_cnt); end
   endtask

   task automatic test_free_run();
      int last = -1;
      int n_start = 0;
      do_reset();
      a_word = 14'h1ABC; a_ready = 1;
      for (int i = 0; i <= 850; i++) begin
         if (i > 0) @(negedge clk);
         if (a_start) begin
            n_chk++;
            if (i != ((n_start == 0) ? 80 : last + 80))
               begin n_fail++; $display("FAIL free_run_start_time: got cycle %0d expected %0d", i, (n_start == 0) ? 80 : last + 80); end
            last = i; n_start++;
         end
         if (i == 0) a_acq_en = 1;
      end
      n_chk++;
      if (n_start != 10) begin n_fail++; $display("FAIL free_run_starts: got %0d expected 10", n_start); end
      n_chk++;
      if (a_cnt !== 32'd10) begin n_fail++; $display("FAIL free_run_cnt: got %0d expected 10", a_cnt); end
      n_chk++;
      if (a_data !== 14'h1ABC || a_miss !== 1'b0)
         begin n_fail++; $display("FAIL free_run_data: got %0h missed %b expected 1abc missed 0", a_data, a_miss); end
      a_acq_en = 0;
   endtask

   task automatic test_overrun();
      do_reset();
      a_ready = 0; a_word = 14'h0001; a_single = 1;
      @(negedge clk); a_single = 0;
      for (int w = 0; w < 40 && !a_valid; w++) @(negedge clk);
      n_chk++;
      if (a_valid !== 1'b1 || a_data !== 14'h0001 || a_ovr !== 1'b0)
         begin n_fail++; $display("FAIL overrun_first: got valid %b data %0h ovr %b expected 1 0001 0", a_valid, a_data, a_ovr); end
      a_word = 14'h0002; a_single = 1;
      @(negedge clk); a_single = 0;
      repeat (34) @(negedge clk);
      n_chk++;
      if (a_valid !== 1'b1 || a_data !== 14'h0002 || a_ovr !== 1'b1 || a_cnt !== 32'd2)
         begin n_fail++; $display("FAIL overrun_second: got valid %b data %0h ovr %b cnt %0d expected 1 0002 1 2", a_valid, a_data, a_ovr, a_cnt); end
      a_ready = 1;
      @(negedge clk); a_ready = 0;
      n_chk++;
      if (a_valid !== 1'b0) begin n_fail++; $display("FAIL overrun_drain: got valid %b expected 0", a_valid); end
   endtask

   task automatic test_missed();
      int free_at = 0;
      int start_at = -1;
      int n_start = 0;
      int exp_start = 0;
      logic exp_miss = 0;
      do_reset();
      b_ready = 1;
      for (int i = 0; i < 300; i++) begin
         if (i > 0) @(negedge clk);
         n_chk++;
         if (b_start !== (i == start_at) || b_miss !== exp_miss)
            begin n_fail++; $display("FAIL missed_cycle %0d: got start %b missed %b expected %b %b", i, b_start, b_miss, i == start_at, exp_miss); end
         if (b_start) n_start++;
         if (i == 0) b_acq_en = 1;
         if (i % 16 == 15) begin
            if (i >= free_at) begin start_at = i + 1; free_at = i + 32; exp_start++; end
            else exp_miss = 1;
         end
      end
      n_chk++;
      if (n_start != exp_start) begin n_fail++; $display("FAIL missed_starts: got %0d expected %0d", n_start, exp_start); end
      b_acq_en = 0;
   endtask

   task automatic test_timeout();
      do_reset();
      a_stuck = 1; a_single = 1;
      for (int i = 1; i <= 260; i++) begin
         @(negedge clk);
         if (i == 1) begin
            a_single = 0;
            n_chk++;
            if (a_start !== 1'b1) begin n_fail++; $display("FAIL timeout_start: got %b expected 1", a_start); end
         end
         if (i == 256) begin
            n_chk++;
            if (a_to !== 1'b0) begin n_fail++; $display("FAIL timeout_early: got %b expected 0", a_to); end
         end
         if (i == 257) begin
            n_chk++;
            if ({a_to, a_busy, a_valid} !== 3'b100)
               begin n_fail++; $display("FAIL timeout_hit: got to/busy/valid %b expected 100", {a_to, a_busy, a_valid}); end
         end
      end
      a_stuck = 0;
      repeat (35) @(negedge clk);
      n_chk++;
      if (a_to !== 1'b1 || a_valid !== 1'b0 || a_cnt !== 32'd0)
         begin n_fail++; $display("FAIL timeout_sticky: got to %b valid %b cnt %0d expected 1 0 0", a_to, a_valid, a_cnt); end
      a_clr = 1;
      @(negedge clk); a_clr = 0;
      n_chk++;
      if (a_to !== 1'b0) begin n_fail++; $display("FAIL timeout_clear: got %b expected 0", a_to); end
   endtask

   task automatic test_single();
      int n_start = 0;
      do_reset();
      a_ready = 1; a_word = 14'h2A5F;
      for (int i = 0; i < 60; i++) begin
         if (i > 0) @(negedge clk);
         if (a_start) n_start++;
         a_single = (i == 0) || (i == 10);
      end
      a_single = 0;
      n_chk++;
      if (n_start != 1 || a_miss !== 1'b1 || a_cnt !== 32'd1)
         begin n_fail++; $display("FAIL single: got starts %0d missed %b cnt %0d expected 1 1 1", n_start, a_miss, a_cnt); end
   endtask

   task automatic test_reset_mid();
      int n_start = 0;
      do_reset();
      a_ready = 1; a_word = 14'h3333; a_single = 1;
      @(negedge clk); a_single = 0;
      repeat (20) @(negedge clk);
      rst_n = 0;
      #1;
      n_chk++;
      if ({a_busy, a_valid, a_start} !== 3'b000)
         begin n_fail++; $display("FAIL reset_mid_async: got busy/valid/start %b expected 000", {a_busy, a_valid, a_start}); end
      @(negedge clk); rst_n = 1;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (a_start || a_valid) n_start++;
      end
      n_chk++;
      if (n_start != 0 || a_cnt !== 32'd0)
         begin n_fail++; $display("FAIL reset_mid_partial: got activity %0d cnt %0d expected 0 0", n_start, a_cnt); end
   endtask

   task automatic test_random();
      int free_at = 0;
      int req_at = -100;
      int start_at = -1;
      int cap_at = -1;
      logic [DW-1:0] cap_word = '0;
      logic [DW-1:0] md = '0;
      logic [31:0] mc = '0;
      logic mv = 0, ov = 0, ms = 0, req, rdy, clr;
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         if (i > 0) @(negedge clk);
         n_chk++;
         if ({a_start, a_busy} !== {i == start_at, (i > req_at) && (i < free_at)})
            begin n_fail++; $display("FAIL random_ctrl cycle %0d: got start/busy %b expected %b", i, {a_start, a_busy}, {i == start_at, (i > req_at) && (i < free_at)}); end
         n_chk++;
         if (a_valid !== mv || (mv && a_data !== md))
            begin n_fail++; $display("FAIL random_data cycle %0d: got valid %b data %0h expected %b %0h", i, a_valid, a_data, mv, md); end
         n_chk++;
         if ({a_ovr, a_miss, a_to} !== {ov, ms, 1'b0} || a_cnt !== mc)
            begin n_fail++; $display("FAIL random_flags cycle %0d: got %b cnt %0d expected %b cnt %0d", i, {a_ovr, a_miss, a_to}, a_cnt, {ov, ms, 1'b0}, mc); end
         req = ($urandom_range(0, 24) == 0);
         rdy = ($urandom_range(0, 3) != 0);
         clr = ($urandom_range(0, 60) == 0);
         a_single = req; a_ready = rdy; a_clr = clr;
         if (clr) begin ov = 0; ms = 0; end
         if (req) begin
            if (i >= free_at) begin
               req_at = i; start_at = i + 1; cap_at = i + 31; free_at = i + 32;
               cap_word = DW'($urandom); a_word = cap_word;
            end else begin
               ms = 1;
            end
         end
         if (i == cap_at) begin
            if (mv && !rdy) ov = 1;
            md = cap_word; mv = 1; mc = mc + 32'd1;
         end else if (mv && rdy) begin
            mv = 0;
         end
      end
      a_single = 0; a_clr = 0; a_ready = 0;
   endtask

`ifdef ACQ_AVG_EN
   task automatic test_avg();
      logic [DW-1:0] words [4];
      words[0] = 14'd100; words[1] = 14'd101; words[2] = 14'd102; words[3] = 14'd104;
      do_reset();
      for (int k = 0; k < 4; k++) begin
         a_word = words[k]; a_single = 1;
         @(negedge clk); a_single = 0;
         repeat (40) @(negedge clk);
         n_chk++;
         if (a_valid !== (k == 3))
            begin n_fail++; $display("FAIL avg_valid after capture %0d: got %b expected %b", k, a_valid, k == 3); end
      end
      n_chk++;
      if (a_data !== 14'd101 || a_cnt !== 32'd1)
         begin n_fail++; $display("FAIL avg_data: got %0d cnt %0d expected 101 1", a_data, a_cnt); end
   endtask
`endif

   initial begin
      test_reset();
`ifdef ACQ_AVG_EN
      test_avg();
`else
      test_free_run();
      test_overrun();
      test_single();
      test_reset_mid();
      test_random();
`endif
      test_missed();
      test_timeout();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
